// File: rtl/pipeline_stage_reg.sv
// Generic valid/ready pipeline register carrying a pc0/pc4 pair plus payload,
// with flush, an optional 2-entry skid buffer and saturating stall/bubble counters.
module pipeline_stage_reg #(
    parameter int WIDTH     = 32,
    parameter int SKID      = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          pc0_in,
    input  logic [31:0]          pc4_in,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          pc0_out,
    output logic [31:0]          pc4_out,
    output logic [WIDTH-1:0]     data_out,
    input  logic                 flush,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKIDF
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               r_state;
    state_t               w_stateNext;
    logic                 r_inReady;
    logic [31:0]          r_pc0;
    logic [31:0]          r_pc4;
    logic [WIDTH-1:0]     r_data;
    logic [31:0]          r_skidPc0;
    logic [31:0]          r_skidPc4;
    logic [WIDTH-1:0]     r_skidData;
    logic [CNT_WIDTH-1:0] r_stallCnt;
    logic [CNT_WIDTH-1:0] r_bubbleCnt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_loadMainIn;
    logic                 w_loadMainSkid;
    logic                 w_loadSkid;

    assign out_valid  = (r_state != ST_EMPTY);
    // The skid variant hides out_ready behind a flop so upstream sees no long ready path.
    assign in_ready   = (SKID != 0) ? r_inReady : (!out_valid | out_ready);
    assign w_push     = in_valid & in_ready;
    assign w_pop      = out_valid & out_ready;
    assign pc0_out    = r_pc0;
    assign pc4_out    = r_pc4;
    assign data_out   = r_data;
    assign stall_cnt  = r_stallCnt;
    assign bubble_cnt = r_bubbleCnt;

    always_comb begin
        w_stateNext    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        if (flush) begin
            w_stateNext = ST_EMPTY;
        end else if (SKID != 0) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_stateNext  = ST_FULL;
                        w_loadMainIn = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_push && w_pop) begin
                        w_loadMainIn = 1'b1;
                    end else if (w_push) begin
                        w_stateNext = ST_SKIDF;
                        w_loadSkid  = 1'b1;
                    end else if (w_pop) begin
                        w_stateNext = ST_EMPTY;
                    end
                end
                ST_SKIDF: begin
                    if (w_pop) begin
                        w_stateNext    = ST_FULL;
                        w_loadMainSkid = 1'b1;
                    end
                end
                default: w_stateNext = ST_EMPTY;
            endcase
        end else begin
            if (w_push) begin
                w_stateNext  = ST_FULL;
                w_loadMainIn = 1'b1;
            end else if (w_pop) begin
                w_stateNext = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_inReady <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_inReady <= (w_stateNext != ST_SKIDF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc0  <= '0;
            r_pc4  <= '0;
            r_data <= '0;
        end else if (w_loadMainIn) begin
            r_pc0  <= pc0_in;
            r_pc4  <= pc4_in;
            r_data <= data_in;
        end else if (w_loadMainSkid) begin
            r_pc0  <= r_skidPc0;
            r_pc4  <= r_skidPc4;
            r_data <= r_skidData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skidPc0  <= '0;
            r_skidPc4  <= '0;
            r_skidData <= '0;
        end else if (w_loadSkid) begin
            r_skidPc0  <= pc0_in;
            r_skidPc4  <= pc4_in;
            r_skidData <= data_in;
        end
    end

    // Counters ignore flush; only cnt_clear (or reset) zeroes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
        end else if (cnt_clear) begin
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stallCnt != CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + CNT_ONE;
            end
            if (!out_valid && out_ready && (r_bubbleCnt != CNT_MAX)) begin
                r_bubbleCnt <= r_bubbleCnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: a SKID=1 instance (4-bit counters) and a SKID=0
// instance (8-bit counters), directed vectors plus random traffic against a queue model.
module tb_pipeline_stage_reg;

    localparam int W = 16;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        eVld;
        logic        eRdy;
        logic [31:0] ePc;
        int          eStall;
        int          eBub;
    } vec_t;

    typedef struct {
        logic [31:0]  pc0;
        logic [31:0]  pc4;
        logic [W-1:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid [2];
    logic         outReady[2];
    logic         flushIn [2];
    logic         cntClr  [2];
    logic [31:0]  pc0In   [2];
    logic [31:0]  pc4In   [2];
    logic [W-1:0] dIn     [2];
    logic         inRdy   [2];
    logic         outVld  [2];
    logic [31:0]  pc0Out  [2];
    logic [31:0]  pc4Out  [2];
    logic [W-1:0] dOut    [2];
    logic [3:0]   stall0, bubble0;
    logic [7:0]   stall1, bubble1;

    int   nChecks = 0;
    int   nFail   = 0;
    vec_t vecs[16];
    ent_t q0[$];
    ent_t q1[$];
    int   mStall[2];
    int   mBubble[2];

    pipeline_stage_reg #(.WIDTH(W), .SKID(1), .CNT_WIDTH(4)) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(inValid[0]), .in_ready(inRdy[0]),
        .pc0_in(pc0In[0]), .pc4_in(pc4In[0]), .data_in(dIn[0]),
        .out_valid(outVld[0]), .out_ready(outReady[0]),
        .pc0_out(pc0Out[0]), .pc4_out(pc4Out[0]), .data_out(dOut[0]),
        .flush(flushIn[0]), .cnt_clear(cntClr[0]),
        .stall_cnt(stall0), .bubble_cnt(bubble0)
    );

    pipeline_stage_reg #(.WIDTH(W), .SKID(0), .CNT_WIDTH(8)) u_comb (
        .clk(clk), .rst(rst),
        .in_valid(inValid[1]), .in_ready(inRdy[1]),
        .pc0_in(pc0In[1]), .pc4_in(pc4In[1]), .data_in(dIn[1]),
        .out_valid(outVld[1]), .out_ready(outReady[1]),
        .pc0_out(pc0Out[1]), .pc4_out(pc4Out[1]), .data_out(dOut[1]),
        .flush(flushIn[1]), .cnt_clear(cntClr[1]),
        .stall_cnt(stall1), .bubble_cnt(bubble1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int getStall(input int d);
        return (d == 0) ? int'(stall0) : int'(stall1);
    endfunction

    function automatic int getBubble(input int d);
        return (d == 0) ? int'(bubble0) : int'(bubble1);
    endfunction

    function automatic logic [W-1:0] tagOf(input logic [31:0] pc);
        return pc[W-1:0] ^ 16'h5A5A;
    endfunction

    function automatic vec_t mkVec(input logic vld, input logic [31:0] pc, input logic ordy,
                                   input logic fl, input logic eVld, input logic eRdy,
                                   input logic [31:0] ePc, input int eStall, input int eBub);
        vec_t v;
        v.vld = vld; v.pc = pc; v.ordy = ordy; v.fl = fl; v.clr = 1'b0;
        v.eVld = eVld; v.eRdy = eRdy; v.ePc = ePc; v.eStall = eStall; v.eBub = eBub;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Directed drive: pc4 is always pc+4 and the payload is a tag derived from pc.
    task automatic applyStimulus(input int d, input logic vld, input logic [31:0] pc,
                                 input logic ordy, input logic fl, input logic clr);
        inValid[d]  = vld;
        pc0In[d]    = pc;
        pc4In[d]    = pc + 32'd4;
        dIn[d]      = tagOf(pc);
        outReady[d] = ordy;
        flushIn[d]  = fl;
        cntClr[d]   = clr;
    endtask

    task automatic checkReset(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s.d%0d.out_valid", tag, d), 32'(outVld[d]), 32'd0);
            checkOutput($sformatf("%s.d%0d.in_ready", tag, d), 32'(inRdy[d]), 32'd1);
            checkOutput($sformatf("%s.d%0d.pc0_out", tag, d), pc0Out[d], 32'd0);
            checkOutput($sformatf("%s.d%0d.pc4_out", tag, d), pc4Out[d], 32'd0);
            checkOutput($sformatf("%s.d%0d.data_out", tag, d), 32'(dOut[d]), 32'd0);
            checkOutput($sformatf("%s.d%0d.stall_cnt", tag, d), 32'(getStall(d)), 32'd0);
            checkOutput($sformatf("%s.d%0d.bubble_cnt", tag, d), 32'(getBubble(d)), 32'd0);
        end
    endtask

    // Reference model: a FIFO of depth 2 (skid) or 1 (combinational ready).
    function automatic int qSize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ent_t qHead(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic bit modelReady(input int d);
        if (d == 0) return qSize(0) < 2;
        return (qSize(1) == 0) || outReady[1];
    endfunction

    task automatic modelEdge(input int d, input bit push, input bit pop);
        int   cmax;
        ent_t e;
        cmax = (d == 0) ? 15 : 255;
        if (cntClr[d]) begin
            mStall[d]  = 0;
            mBubble[d] = 0;
        end else begin
            if (qSize(d) > 0 && !outReady[d] && mStall[d] < cmax) mStall[d]++;
            if (qSize(d) == 0 && outReady[d] && mBubble[d] < cmax) mBubble[d]++;
        end
        e.pc0 = pc0In[d]; e.pc4 = pc4In[d]; e.data = dIn[d];
        if (flushIn[d]) begin
            if (d == 0) q0.delete(); else q1.delete();
        end else begin
            if (pop) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (push) begin
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit   push[2];
        bit   pop[2];
        ent_t h;

        vecs[0]  = mkVec(1, 32'h100, 1, 0, 1, 1, 32'h100, 0, 1);
        vecs[1]  = mkVec(1, 32'h104, 1, 0, 1, 1, 32'h104, 0, 1);
        vecs[2]  = mkVec(1, 32'h108, 1, 0, 1, 1, 32'h108, 0, 1);
        vecs[3]  = mkVec(0, 32'h0,   1, 0, 0, 1, 32'h0,   0, 1);
        vecs[4]  = mkVec(1, 32'h200, 0, 0, 1, 1, 32'h200, 0, 1);
        vecs[5]  = mkVec(1, 32'h204, 0, 0, 1, 0, 32'h200, 1, 1);
        vecs[6]  = mkVec(0, 32'h0,   0, 0, 1, 0, 32'h200, 2, 1);
        vecs[7]  = mkVec(1, 32'h2F0, 1, 0, 1, 1, 32'h204, 2, 1);
        vecs[8]  = mkVec(0, 32'h0,   1, 0, 0, 1, 32'h0,   2, 1);
        vecs[9]  = mkVec(1, 32'h300, 0, 0, 1, 1, 32'h300, 2, 1);
        vecs[10] = mkVec(1, 32'h304, 0, 0, 1, 0, 32'h300, 3, 1);
        vecs[11] = mkVec(1, 32'h308, 1, 1, 0, 1, 32'h0,   3, 1);
        vecs[12] = mkVec(1, 32'h400, 0, 0, 1, 1, 32'h400, 3, 1);
        vecs[13] = mkVec(1, 32'h404, 0, 1, 0, 1, 32'h0,   4, 1);
        vecs[14] = mkVec(0, 32'h0,   0, 0, 0, 1, 32'h0,   4, 1);
        vecs[15] = mkVec(1, 32'h500, 0, 0, 1, 1, 32'h500, 4, 1);

        doReset();
        #1;
        checkReset("reset");

        // Skid instance: streaming, skid fill, flush, then held full for saturation.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(0, vecs[i].vld, vecs[i].pc, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d.out_valid", i), 32'(outVld[0]), 32'(vecs[i].eVld));
            checkOutput($sformatf("vec%0d.in_ready", i), 32'(inRdy[0]), 32'(vecs[i].eRdy));
            if (vecs[i].eVld) begin
                checkOutput($sformatf("vec%0d.pc0_out", i), pc0Out[0], vecs[i].ePc);
                checkOutput($sformatf("vec%0d.pc4_out", i), pc4Out[0], vecs[i].ePc + 32'd4);
                checkOutput($sformatf("vec%0d.data_out", i), 32'(dOut[0]), 32'(tagOf(vecs[i].ePc)));
            end
            checkOutput($sformatf("vec%0d.stall_cnt", i), 32'(getStall(0)), 32'(vecs[i].eStall));
            checkOutput($sformatf("vec%0d.bubble_cnt", i), 32'(getBubble(0)), 32'(vecs[i].eBub));
        end

        repeat (20) begin
            @(negedge clk);
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        @(posedge clk);
        #1;
        checkOutput("sat.stall_cnt", 32'(getStall(0)), 32'd15);
        checkOutput("sat.pc0_held", pc0Out[0], 32'h500);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        checkOutput("clear.stall_cnt", 32'(getStall(0)), 32'd0);
        checkOutput("clear.bubble_cnt", 32'(getBubble(0)), 32'd0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("postclear.stall_cnt", 32'(getStall(0)), 32'd1);

        // Combinational-ready instance: ready follows out_ready in the same cycle.
        @(negedge clk);
        applyStimulus(1, 1, 32'h600, 0, 0, 0);
        #1;
        checkOutput("comb.empty_ready", 32'(inRdy[1]), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("comb.first_pc0", pc0Out[1], 32'h600);
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 0, 0);
        #1;
        checkOutput("comb.full_stalled_ready", 32'(inRdy[1]), 32'd0);
        @(negedge clk);
        applyStimulus(1, 1, 32'h604, 1, 0, 0);
        #1;
        checkOutput("comb.full_released_ready", 32'(inRdy[1]), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("comb.replace_pc0", pc0Out[1], 32'h604);
        checkOutput("comb.replace_valid", 32'(outVld[1]), 32'd1);
        checkOutput("comb.stall_cnt", 32'(getStall(1)), 32'd1);
        @(negedge clk);
        applyStimulus(1, 1, 32'h608, 1, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("comb.replace2_pc0", pc0Out[1], 32'h608);
        checkOutput("comb.replace2_data", 32'(dOut[1]), 32'(tagOf(32'h608)));
        @(negedge clk);
        applyStimulus(1, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("comb.drain_valid", 32'(outVld[1]), 32'd0);
        checkOutput("comb.bubble_cnt", 32'(getBubble(1)), 32'd0);
        @(negedge clk);
        applyStimulus(1, 1, 32'h700, 0, 0, 0);
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("async.pre_full0", 32'(outVld[0]), 32'd1);
        checkOutput("async.pre_full1", 32'(outVld[1]), 32'd1);

        // Asynchronous reset asserted between edges while both instances hold entries.
        #2;
        rst = 1'b1;
        #1;
        checkReset("async");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the queue model, with phases biased toward stalls and bubbles.
        q0.delete();
        q1.delete();
        mStall  = '{0, 0};
        mBubble = '{0, 0};
        for (int cyc = 0; cyc < 2400; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int phase;
                phase       = (cyc / 120) % 3;
                inValid[d]  = (phase == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
                outReady[d] = (phase == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 4) < 3);
                pc0In[d]    = $urandom;
                pc4In[d]    = $urandom;
                dIn[d]      = W'($urandom);
                flushIn[d]  = ($urandom_range(0, 19) == 0);
                cntClr[d]   = ($urandom_range(0, 99) == 0);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("rand%0d.d%0d.out_valid", cyc, d), 32'(outVld[d]), 32'(qSize(d) > 0));
                checkOutput($sformatf("rand%0d.d%0d.in_ready", cyc, d), 32'(inRdy[d]), 32'(modelReady(d)));
                if (qSize(d) > 0) begin
                    h = qHead(d);
                    checkOutput($sformatf("rand%0d.d%0d.pc0_out", cyc, d), pc0Out[d], h.pc0);
                    checkOutput($sformatf("rand%0d.d%0d.pc4_out", cyc, d), pc4Out[d], h.pc4);
                    checkOutput($sformatf("rand%0d.d%0d.data_out", cyc, d), 32'(dOut[d]), 32'(h.data));
                end
                checkOutput($sformatf("rand%0d.d%0d.stall_cnt", cyc, d), 32'(getStall(d)), 32'(mStall[d]));
                checkOutput($sformatf("rand%0d.d%0d.bubble_cnt", cyc, d), 32'(getBubble(d)), 32'(mBubble[d]));
                push[d] = inValid[d] && modelReady(d);
                pop[d]  = (qSize(d) > 0) && outReady[d];
            end
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                modelEdge(d, push[d], pop[d]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_reg.md
# pipeline_stage_reg

Parametrised valid/ready pipeline register for the RV32E core. It replaces the per-stage ad-hoc stall registers (IF/ID and later stages) with one generic block. It carries a 32-bit pc0/pc4 pair plus a WIDTH-bit payload, and supports flush and an optional 2-entry skid buffer that breaks the combinational ready path. It also keeps saturating stall and bubble counters for performance analysis.

## Interface
Parameters:
- WIDTH, 32, payload width in bits; legal range is 1 and up.
- SKID, 1, selects the mode. 1 gives a 2-entry skid buffer with registered in_ready. 0 gives a single entry with combinational in_ready.
- CNT_WIDTH, 16, width of each performance counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a valid entry.
- in_ready  output  1  block can accept an entry this cycle.
- pc0_in  input  32  PC of the entry.
- pc4_in  input  32  PC+4 of the entry.
- data_in  input  WIDTH  payload.
- out_valid  output  1  output entry is valid.
- out_ready  input  1  downstream accepts the output this cycle.
- pc0_out  output  32  PC of the head entry.
- pc4_out  output  32  PC+4 of the head entry.
- data_out  output  WIDTH  payload of the head entry.
- flush  input  1  synchronously discards all held entries.
- cnt_clear  input  1  synchronously zeroes both counters.
- stall_cnt  output  CNT_WIDTH  cycles where out_valid=1 and out_ready=0.
- bubble_cnt  output  CNT_WIDTH  cycles where out_valid=0 and out_ready=1.

## Operation
Definitions:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- The main register drives the outputs. The skid register exists only when SKID=1.

States, SKID=1:
- EMPTY: out_valid=0, in_ready=1.
  - push → FULL; main takes the input.
- FULL: out_valid=1, in_ready=1.
  - push & pop → FULL; main takes the input.
  - push & !pop → SKIDF; skid takes the input and main holds.
  - !push & pop → EMPTY.
  - neither → FULL, everything holds.
- SKIDF: out_valid=1, in_ready=0.
  - pop → FULL; main takes skid.
  - otherwise hold.

States, SKID=0:
- EMPTY/FULL only.
- in_ready = !out_valid | out_ready, combinational.
- push loads main.
- pop & !push → EMPTY.

Flush:
- flush has priority over push and pop.
- Next state is EMPTY. Both entries are discarded, and any input presented in the flush cycle is dropped (not captured).
- Data registers may keep stale contents; only the valid state is cleared.
- Flush does not affect the counters.

Data hold:
- While out_valid=1 and out_ready=0, pc0_out, pc4_out and data_out are stable.
- Entries leave in strict FIFO order, with no duplication and no loss.

Counters:
- Evaluated every cycle from the current out_valid and out_ready.
- Each counter saturates at 2^CNT_WIDTH−1; there is no wrap.
- cnt_clear has priority over increment.

## Timing
Reset values:
- State is EMPTY, so out_valid=0.
- in_ready=1 in both modes (in SKID=0 because the block is empty).
- pc0_out, pc4_out and data_out = 0.
- stall_cnt and bubble_cnt = 0.

Latency and throughput:
- An entry pushed at edge N appears on the outputs after edge N, i.e. 1-cycle latency.
- Sustained throughput is 1 entry per cycle when out_ready=1.

Ready paths:
- In SKID=1, in_ready is a register output with no combinational dependence on out_ready.
- After a stall it reasserts one cycle after the pop that empties skid.
- In SKID=0, in_ready follows out_ready combinationally.
- out_valid is always registered.

Asynchronous reset mid-operation:
- Immediately returns every output to its reset value, including counters.
- Any held entries are lost.

## Test plan
- Streaming: reset, then push pc0=0x100,0x104,0x108 back-to-back with out_ready=1. Outputs appear on cycles 1, 2, 3 in order, pc4_out = pc0_out+4, and stall_cnt stays 0.
- Skid fill (SKID=1): push A=0x200 with out_ready=0, then B=0x204. After the second edge, in_ready=0 and out shows A. Raise out_ready: A, then B. in_ready returns to 1 one cycle after A pops, and stall_cnt=2.
- Flush: with SKIDF state holding 0x300/0x304, assert flush together with in_valid (C=0x308). Next cycle out_valid=0 and in_ready=1, C never appears, and stall_cnt is unchanged.
- Counter saturation: with CNT_WIDTH=4, hold the block full with out_ready=0 for 20 cycles. stall_cnt=15. Then cnt_clear → 0 on the next cycle.
- SKID=0 mode: with the block full and out_ready=0, in_ready=0 in the same cycle. Raise out_ready=1 and in_ready=1 combinationally, and a simultaneous push and pop replaces the head with zero bubbles; bubble_cnt stays 0.
- Asynchronous reset: assert rst mid-cycle while the block is full. out_valid, outputs and counters go to 0 before the next clk edge, and in_ready=1.
